// File: rtl/pc_redirect_unit_pkg.sv
// cpu_pc_pkg: shared FSM states, PC increment and redirect-source encoding
// for the PC sequencer.
package cpu_pc_pkg;
   typedef enum logic [1:0] {S_BOOT, S_RUN, S_SLOT, S_HALT} state_t;
   typedef enum logic [1:0] {SRC_NONE, SRC_BR, SRC_JMP, SRC_JR} src_t;
   localparam logic [31:0] PC_INC = 32'd4;
endpackage

// File: rtl/pc_redirect_unit_if.sv
// pc_redirect_unit_if: fetch handshake plus resolved branch/jump/jr redirect
// inputs; master is the PC unit, slave is the surrounding pipeline and imem.
interface pc_redirect_unit_if;
   logic        fetch_ready;
   logic        pc_valid;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        br_valid;
   logic        br_taken;
   logic [31:0] br_base;
   logic [31:0] br_offset_sl2;
   logic        jmp_valid;
   logic [25:0] jmp_index;
   logic        jr_valid;
   logic [31:0] jr_addr;
   modport master (
      output pc, pc_valid, pc_plus4,
      input  fetch_ready, br_valid, br_taken, br_base, br_offset_sl2,
             jmp_valid, jmp_index, jr_valid, jr_addr
   );
   modport slave (
      input  pc, pc_valid, pc_plus4,
      output fetch_ready, br_valid, br_taken, br_base, br_offset_sl2,
             jmp_valid, jmp_index, jr_valid, jr_addr
   );
endinterface

// File: rtl/pc_redirect_unit_target_calc.sv
// pc_target_calc: picks the winning redirect source (jr > jmp > br), forms its
// target address and flags a misaligned register target.
module pc_target_calc
   import cpu_pc_pkg::*;
(
   input  logic        br_valid,
   input  logic        br_taken,
   input  logic [31:0] br_base,
   input  logic [31:0] br_offset_sl2,
   input  logic        jmp_valid,
   input  logic [25:0] jmp_index,
   input  logic        jr_valid,
   input  logic [31:0] jr_addr,
   output src_t        src,
   output logic [31:0] target,
   output logic        misalign
);
   assign src = jr_valid ? SRC_JR : jmp_valid ? SRC_JMP : (br_valid && br_taken) ? SRC_BR : SRC_NONE;
   assign misalign = jr_valid && (jr_addr[1:0] != 2'b00);
   always_comb
      target = (src == SRC_JR)  ? jr_addr :
               (src == SRC_JMP) ? {br_base[31:28], jmp_index, 2'b00} :
                                  br_base + br_offset_sl2;
endmodule

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: PC register and next-PC sequencer honouring one branch delay slot.
// Defining PC_TRACE_EN adds a saturating redirect_cnt output.
module pc_redirect_unit
   import cpu_pc_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef PC_TRACE_EN
   , parameter int CNT_W = 16
`endif
) (
   input  logic               clk,
   input  logic               rst_n,
   pc_redirect_unit_if.master bus,
   output logic               redirect_pending,
   output logic               misalign_err
`ifdef PC_TRACE_EN
   , output logic [CNT_W-1:0] redirect_cnt
`endif
);
   state_t      state;
   src_t        src;
   logic [31:0] target;
   logic [31:0] tgt_q;
   logic        misalign;
   logic        redirect;
   pc_target_calc u_calc (
      .br_valid      (bus.br_valid),
      .br_taken      (bus.br_taken),
      .br_base       (bus.br_base),
      .br_offset_sl2 (bus.br_offset_sl2),
      .jmp_valid     (bus.jmp_valid),
      .jmp_index     (bus.jmp_index),
      .jr_valid      (bus.jr_valid),
      .jr_addr       (bus.jr_addr),
      .src           (src),
      .target        (target),
      .misalign      (misalign)
   );
   assign redirect     = (src != SRC_NONE) && !misalign;
   assign bus.pc_plus4 = bus.pc + PC_INC;
   // pc_valid is high exactly in S_RUN/S_SLOT, so fetch_ready alone marks acceptance there
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state            <= S_BOOT;
         bus.pc           <= RESET_PC;
         bus.pc_valid     <= 1'b0;
         redirect_pending <= 1'b0;
         misalign_err     <= 1'b0;
         tgt_q            <= 32'd0;
      end else
         case (state)
            S_BOOT: begin
               state        <= S_RUN;
               bus.pc_valid <= 1'b1;
            end
            S_RUN:
               if (misalign) begin
                  state        <= S_HALT;
                  bus.pc_valid <= 1'b0;
                  misalign_err <= 1'b1;
                  if (bus.fetch_ready) bus.pc <= bus.pc_plus4;
               end else if (redirect && bus.fetch_ready)
                  bus.pc <= target;
               else if (redirect) begin
                  tgt_q            <= target;
                  state            <= S_SLOT;
                  redirect_pending <= 1'b1;
               end else if (bus.fetch_ready)
                  bus.pc <= bus.pc_plus4;
            S_SLOT:
               if (bus.fetch_ready) begin
                  bus.pc           <= tgt_q;
                  state            <= S_RUN;
                  redirect_pending <= 1'b0;
               end
            default: ;
         endcase
`ifdef PC_TRACE_EN
   logic applied;
   assign applied = bus.fetch_ready && ((state == S_RUN && redirect) || state == S_SLOT);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) redirect_cnt <= '0;
      else if (applied && redirect_cnt != '1) redirect_cnt <= redirect_cnt + 1'b1;
`endif
endmodule
